// File: rtl/matmul_dispatcher_if.sv
// Handshake bus between the matrix dispatcher and one inner_product engine.
// The master drives the row/column operands and strobes; the slave returns acks and the result.
interface matmul_dispatcher_if #(
  parameter int N = 4
);
  logic [32*N-1:0] ip_row;
  logic [32*N-1:0] ip_column;
  logic            ip_row_stb;
  logic            ip_column_stb;
  logic            ip_out_ack;
  logic            ip_row_ack;
  logic            ip_column_ack;
  logic [31:0]     ip_out;
  logic            ip_out_stb;

  modport master (
    output ip_row, ip_column, ip_row_stb, ip_column_stb, ip_out_ack,
    input  ip_row_ack, ip_column_ack, ip_out, ip_out_stb
  );

  modport slave (
    input  ip_row, ip_column, ip_row_stb, ip_column_stb, ip_out_ack,
    output ip_row_ack, ip_column_ack, ip_out, ip_out_stb
  );
endinterface

// File: rtl/matmul_dispatcher.sv
// Sequences an N x N matrix multiply through a single inner_product engine:
// latches A and B, issues (row i, column j) per element, and gathers results into C.
module matmul_dispatcher #(
  parameter int N = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [32*N*N-1:0]     a_in,
  input  logic [32*N*N-1:0]     b_in,
  output logic [32*N*N-1:0]     c_out,
  output logic                  busy,
  output logic                  done,
  matmul_dispatcher_if.master   ip
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RES,
    STORE,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [32*N*N-1:0] a_q;
  logic [32*N*N-1:0] b_q;
  logic [IW-1:0]     i_q;
  logic [IW-1:0]     j_q;
  logic              row_seen;
  logic              col_seen;
  logic              armed;

  logic acks_done;
  logic last_op;
  logic capture;

  // Current-cycle acks count as well as the sticky ones, so same-cycle acks finish ISSUE at once.
  assign acks_done = (row_seen | ip.ip_row_ack) & (col_seen | ip.ip_column_ack);
  assign last_op   = (i_q == IW'(N-1)) && (j_q == IW'(N-1));
  // A high ip_out_stb only counts after a low has been seen in WAIT_RES (rejects stale levels).
  assign capture   = armed & ip.ip_out_stb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (start)     state_nx = ISSUE;
      ISSUE:    if (acks_done) state_nx = WAIT_RES;
      WAIT_RES: if (capture)   state_nx = STORE;
      STORE:    state_nx = last_op ? DONE : ISSUE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    ip.ip_row_stb    = 1'b0;
    ip.ip_column_stb = 1'b0;
    ip.ip_out_ack    = 1'b0;
    done             = 1'b0;
    case (state)
      ISSUE: begin
        ip.ip_row_stb    = 1'b1;
        ip.ip_column_stb = 1'b1;
        ip.ip_out_ack    = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Operand selection: row i of A and column j of B from the latched copies.
  always_comb begin
    ip.ip_row    = '0;
    ip.ip_column = '0;
    for (int unsigned k = 0; k < N; k++) begin
      ip.ip_row[32*k +: 32]    = a_q[32*(int'(i_q)*N + int'(k)) +: 32];
      ip.ip_column[32*k +: 32] = b_q[32*(int'(k)*N + int'(j_q)) +: 32];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      c_out    <= '0;
      i_q      <= '0;
      j_q      <= '0;
      row_seen <= 1'b0;
      col_seen <= 1'b0;
      armed    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q      <= a_in;
            b_q      <= b_in;
            c_out    <= '0;
            i_q      <= '0;
            j_q      <= '0;
            row_seen <= 1'b0;
            col_seen <= 1'b0;
            armed    <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ISSUE: begin
          if (ip.ip_row_ack)    row_seen <= 1'b1;
          if (ip.ip_column_ack) col_seen <= 1'b1;
          if (acks_done)        armed    <= 1'b0;
        end
        WAIT_RES: begin
          if (!ip.ip_out_stb) armed <= 1'b1;
          if (capture) begin
            c_out[32*(int'(i_q)*N + int'(j_q)) +: 32] <= ip.ip_out;
          end
        end
        STORE: begin
          row_seen <= 1'b0;
          col_seen <= 1'b0;
          if (j_q == IW'(N-1)) begin
            j_q <= '0;
            i_q <= last_op ? '0 : i_q + IW'(1);
          end else begin
            j_q <= j_q + IW'(1);
          end
          // Dropping busy here makes its fall coincide with the done pulse.
          if (last_op) busy <= 1'b0;
        end
        DONE: busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/matmul_dispatcher.md
Name: matmul_dispatcher

Overview:
- Initiator for the inner-product engine: computes C = A x B for N x N matrices of 32-bit IEEE-754 words.
- Latches both matrices on start, then for each (i,j) issues row i of A and column j of B to one inner_product instance over its stb/ack handshake.
- Collects each scalar result into C and pulses done.
- Sits between the top-level matrix multiplier and the inner_product instance. It performs no arithmetic itself.

Parameters:
- N, 4, matrix dimension; word width is fixed at 32.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  request a multiply; sampled only in IDLE.
- a_in  in  32*N*N  matrix A; element (r,c) at bits [32*(r*N+c)+31 : 32*(r*N+c)].
- b_in  in  32*N*N  matrix B; same packing as a_in.
- c_out  out  32*N*N  result matrix C; same packing as a_in.
- busy  out  1  high from start acceptance until DONE.
- done  out  1  one-cycle pulse when C is complete.
- ip_row  out  32*N  row i of A; element k at [32k+31:32k].
- ip_column  out  32*N  column j of B; element k = B(k,j).
- ip_row_stb  out  1  row valid.
- ip_column_stb  out  1  column valid.
- ip_out_ack  out  1  result-ready-to-accept; driven identical to ip_row_stb.
- ip_row_ack  in  1  engine accepted row.
- ip_column_ack  in  1  engine accepted column.
- ip_out  in  32  inner-product result.
- ip_out_stb  in  1  result valid.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; busy=0, done=0.
  - All stb and ack outputs = 0; ip_row/ip_column = 0; c_out = 0.
  - i=j=0; sticky ack flags cleared.
  - Reset mid-operation abandons the job with no partial done.
- States: IDLE, ISSUE, WAIT_RES, STORE, DONE.
- IDLE:
  - On start=1: latch a_in/b_in into internal registers; clear c_out; i=j=0; busy<=1; go to ISSUE.
  - Otherwise remain in IDLE.
  - Later changes on a_in/b_in do not affect a running job.
- ISSUE:
  - ip_row, ip_column driven from the latched matrices for (i,j).
  - ip_row_stb = ip_column_stb = ip_out_ack = 1.
  - Each incoming ack sets its own sticky flag; acks may arrive in different cycles or the same cycle.
  - In the cycle where both flags (including the current inputs) are set: the registered strobes drop to 0 next cycle; clear the "armed" flag; go to WAIT_RES.
- WAIT_RES:
  - Strobes stay low; data stays stable.
  - ip_out_stb may still be high as a stale level from the previous result. The result is accepted only after ip_out_stb has been sampled 0 at least once in this state: the first 0 sets "armed".
  - On the first cycle with armed=1 and ip_out_stb=1: write ip_out into C(i,j) and go to STORE.
  - No timeout: the block waits indefinitely.
- STORE:
  - One gap cycle with all strobes low; clear the sticky ack flags.
  - Advance the index: j=j+1; if j==N-1, then j=0 and i=i+1.
  - If (i,j) was (N-1,N-1), go to DONE; otherwise go to ISSUE.
- DONE:
  - done=1 for exactly one cycle; busy<=0; go to IDLE.
  - c_out holds its value until the next accepted start or reset.
- start while busy=1 is ignored (not queued).
- Total job latency is the sum over N² operations of (ISSUE + WAIT_RES + 1) cycles, plus 2 cycles.
- Counters i and j are clog2(N) bits wide (minimum 1).

Test Plan:
- Identity case, N=2: A = {1.0,2.0,3.0,4.0} (0x3F800000, 0x40000000, 0x40400000, 0x40800000), B = identity. Use the real inner_product as the engine.
  -> c_out == A; done pulses once; busy falls the same cycle done rises.
- Indexing check, N=2, behavioural engine returning {i,j} encoded as 0x000000ij after 5 cycles.
  -> c_out elements equal 0x00, 0x01, 0x10, 0x11 at packed positions 0..3.
  -> ip_column for (0,1) equals {B(1,1), B(0,1)}.
- Ack skew: ip_row_ack in cycle 2 of ISSUE, ip_column_ack in cycle 4.
  -> Strobes drop only after cycle 4; each operation is issued exactly once.
- Stale strobe: engine holds ip_out_stb=1 from the previous result for 3 cycles into the next WAIT_RES.
  -> No capture until ip_out_stb goes 0 then 1; no duplicate or wrong result in C.
- Reset mid-job: assert rst during operation (1,0).
  -> Immediately busy=0, stb=0, c_out=0; no done pulse. A fresh start completes correctly.
- start pulsed while busy, with different a_in: ignored; the result matches the first matrices; exactly one done.
